// File: rtl/lsu_dm_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_dm_port : byte/half/word load-store front end for a word-only dm       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module lsu_dm_port #(
  parameter int DM_WORDS = 64
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [29:0] dm_Ad,
  output logic [31:0] dm_WrData,
  output logic        dm_DMWr,
  input  logic [31:0] dm_DM
);

  localparam logic [31:0] c_ADDR_LIMIT = 32'(DM_WORDS * 4);
  localparam logic [1:0]  c_SZ_BYTE    = 2'b00;
  localparam logic [1:0]  c_SZ_HALF    = 2'b01;
  localparam logic [1:0]  c_SZ_WORD    = 2'b10;
  localparam logic [1:0]  c_SZ_RSVD    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_CAPT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_we;
  logic        r_sign;
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;
  logic [29:0] r_ad;
  logic [31:0] r_wrdata;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_rdata;

  logic        w_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign w_err = (req_size == c_SZ_RSVD)
               | ((req_size == c_SZ_HALF) & req_addr[0])
               | ((req_size == c_SZ_WORD) & (|req_addr[1:0]))
               | (req_addr >= c_ADDR_LIMIT);

  // Lane extraction and extension of the word returned by dm.
  always_comb begin
    w_byte = dm_DM[7:0];
    case (r_lane)
      2'd0: w_byte = dm_DM[7:0];
      2'd1: w_byte = dm_DM[15:8];
      2'd2: w_byte = dm_DM[23:16];
      2'd3: w_byte = dm_DM[31:24];
    endcase
    w_half = r_lane[1] ? dm_DM[31:16] : dm_DM[15:0];
    case (r_size)
      c_SZ_BYTE: w_load = {{24{r_sign & w_byte[7]}}, w_byte};
      c_SZ_HALF: w_load = {{16{r_sign & w_half[15]}}, w_half};
      default:   w_load = dm_DM;
    endcase
  end

  // Only sub-word stores reach the merge; word stores bypass the read.
  always_comb begin
    w_merged = dm_DM;
    if (r_size == c_SZ_HALF) begin
      if (r_lane[1]) w_merged[31:16] = r_wdata;
      else           w_merged[15:0]  = r_wdata;
    end else begin
      case (r_lane)
        2'd0: w_merged[7:0]   = r_wdata[7:0];
        2'd1: w_merged[15:8]  = r_wdata[7:0];
        2'd2: w_merged[23:16] = r_wdata[7:0];
        2'd3: w_merged[31:24] = r_wdata[7:0];
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_sign       <= 1'b0;
      r_size       <= 2'b00;
      r_lane       <= 2'b00;
      r_wdata      <= 16'h0;
      r_ad         <= 30'h0;
      r_wrdata     <= 32'h0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rdata      <= 32'h0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_sign     <= req_sign;
            r_size     <= req_size;
            r_lane     <= req_addr[1:0];
            r_wdata    <= req_wdata[15:0];
            r_resp_err <= w_err;
            if (w_err) begin
              r_state      <= S_DONE;
              r_resp_valid <= 1'b1;
            end else begin
              r_ad <= req_addr[31:2];
              if (req_we && (req_size == c_SZ_WORD)) begin
                r_wrdata <= req_wdata;
                r_state  <= S_WRITE;
              end else begin
                r_state <= S_READ;
              end
            end
          end
        end
        S_READ: r_state <= S_CAPT;
        S_CAPT: begin
          if (r_we) begin
            r_wrdata <= w_merged;
            r_state  <= S_WRITE;
          end else begin
            r_rdata      <= w_load;
            r_state      <= S_DONE;
            r_resp_valid <= 1'b1;
          end
        end
        S_WRITE: begin
          r_state      <= S_DONE;
          r_resp_valid <= 1'b1;
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_resp_err <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_rdata;
  assign dm_Ad      = r_ad;
  assign dm_WrData  = r_wrdata;
  assign dm_DMWr    = (r_state == S_WRITE);

endmodule
`default_nettype wire

// File: tb/tb_lsu_dm_port.sv
`default_nettype none
// Self-checking bench for lsu_dm_port: dm model plus a byte-array reference of memory.
module tb_lsu_dm_port;
  localparam int DM_WORDS = 64;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_sign = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [29:0] dm_Ad;
  logic [31:0] dm_WrData;
  logic        dm_DMWr;
  logic [31:0] dm_DM;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_count = 0;
  logic [31:0] last_rdata = 32'h0;

  logic        pre_en = 1'b0;
  int          pre_idx = 0;
  logic [31:0] pre_data = 32'h0;
  logic [31:0] mem [DM_WORDS];
  logic [7:0]  ref_mem [DM_WORDS*4];

  lsu_dm_port #(.DM_WORDS(DM_WORDS)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .dm_Ad(dm_Ad), .dm_WrData(dm_WrData), .dm_DMWr(dm_DMWr), .dm_DM(dm_DM)
  );

  always #5 Clk = ~Clk;

  // dm: synchronous write, registered read
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (pre_en) mem[pre_idx] <= pre_data;
    else if (dm_DMWr) begin
      mem[int'(dm_Ad) % DM_WORDS] <= dm_WrData;
      wr_count <= wr_count + 1;
    end else dm_DM <= mem[int'(dm_Ad) % DM_WORDS];
  end

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sign,
                                           input logic [31:0] addr);
    int nb = 1 << size;
    longint v = 0;
    for (int i = 0; i < nb; i++) v += longint'(ref_mem[addr + i]) << (8 * i);
    if (sign && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= (longint'(1) << (8 * nb));
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    int nb = 1 << size;
    for (int i = 0; i < nb; i++) ref_mem[addr + i] = 8'(wdata >> (8 * i));
  endtask

  function automatic logic exp_err(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
           (size == 2'd2 && addr % 4 != 0) || (longint'(addr) >= DM_WORDS * 4);
  endfunction

  // Drive one request, wait for its response; lat=0 means no response within bound.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic err, output logic [31:0] rdata,
                        output int nwr, output int acc_cyc, output int rsp_cyc);
    int n = 0;
    int w0;
    req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
    req_addr = addr; req_wdata = wdata;
    @(negedge Clk);
    while (!req_ready && n < 20) begin @(negedge Clk); n++; end
    @(posedge Clk);
    #1;
    w0 = wr_count;
    acc_cyc = cyc;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_sign = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (resp_valid) begin lat = k; break; end
      @(posedge Clk);
      #1;
    end
    err = resp_err;
    rdata = resp_rdata;
    nwr = wr_count - w0;
    rsp_cyc = cyc;
  endtask

  task automatic test_reset();
    for (int i = 0; i < DM_WORDS; i++) begin
      pre_en = 1'b1; pre_idx = i; pre_data = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = 8'(pre_data >> (8 * b));
      @(posedge Clk);
      #1;
    end
    pre_en = 1'b0;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata); end
    checks++; if (dm_DMWr !== 1'b0) begin errors++; $display("FAIL reset_dmwr: got %b expected 0", dm_DMWr); end
    checks++; if (dm_Ad !== 30'h0) begin errors++; $display("FAIL reset_ad: got %h expected 0", dm_Ad); end
    checks++; if (dm_WrData !== 32'h0) begin errors++; $display("FAIL reset_wrdata: got %h expected 0", dm_WrData); end
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_word_rw();
    int lat, nwr, a, r; logic err; logic [31:0] rd;
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, lat, err, rd, nwr, a, r);
    ref_store(2'd2, 32'h10, 32'hDEADBEEF);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wstore_lat: got %0d expected 2", lat); end
    checks++; if (err !== 1'b0 || nwr !== 1) begin errors++; $display("FAIL wstore_resp: err %b writes %0d expected 0/1", err, nwr); end
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, err, rd, nwr, a, r);
    last_rdata = 32'hDEADBEEF;
    checks++; if (lat !== 3) begin errors++; $display("FAIL wload_lat: got %0d expected 3", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wload_data: got %h expected deadbeef", rd); end
  endtask

  task automatic test_subword();
    int lat, nwr, a, r; logic err; logic [31:0] rd;
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF5A, lat, err, rd, nwr, a, r);
    ref_store(2'd0, 32'h11, 32'h5A);
    checks++; if (lat !== 4 || nwr !== 1) begin errors++; $display("FAIL bstore: lat %0d writes %0d expected 4/1", lat, nwr); end
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, err, rd, nwr, a, r);
    checks++; if (rd !== 32'hDEAD5AEF) begin errors++; $display("FAIL bstore_merge: got %h expected dead5aef", rd); end
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, lat, err, rd, nwr, a, r);
    checks++; if (rd !== 32'hFFFFFFDE) begin errors++; $display("FAIL bload_signed: got %h expected ffffffde", rd); end
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, lat, err, rd, nwr, a, r);
    checks++; if (rd !== 32'h000000DE) begin errors++; $display("FAIL bload_unsigned: got %h expected 000000de", rd); end
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, lat, err, rd, nwr, a, r);
    checks++; if (rd !== 32'hFFFFDEAD) begin errors++; $display("FAIL hload_signed: got %h expected ffffdead", rd); end
    do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'hABCD1234, lat, err, rd, nwr, a, r);
    ref_store(2'd1, 32'h12, 32'h1234);
    checks++; if (lat !== 4 || rd !== 32'hFFFFDEAD) begin errors++; $display("FAIL hstore: lat %0d rdata %h expected 4/ffffdead", lat, rd); end
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, err, rd, nwr, a, r);
    last_rdata = 32'h12345AEF;
    checks++; if (rd !== 32'h12345AEF) begin errors++; $display("FAIL hstore_merge: got %h expected 12345aef", rd); end
  endtask

  task automatic test_errors();
    logic [1:0]  sz [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] ad [4] = '{32'h11, 32'h102, 32'h20, 32'h100};
    logic        we [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int lat, nwr, a, r; logic err; logic [31:0] rd;
    for (int i = 0; i < 4; i++) begin
      do_req(we[i], sz[i], 1'b1, ad[i], 32'h0BADF00D, lat, err, rd, nwr, a, r);
      checks++; if (lat !== 1 || err !== 1'b1) begin errors++; $display("FAIL err_resp%0d: lat %0d err %b expected 1/1", i, lat, err); end
      checks++; if (nwr !== 0 || rd !== last_rdata) begin errors++; $display("FAIL err_side%0d: writes %0d rdata %h expected 0/%h", i, nwr, rd, last_rdata); end
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, err, rd, nwr, a, r);
    checks++; if (rd !== 32'h12345AEF || err !== 1'b0) begin errors++; $display("FAIL err_mem10: got %h err %b expected 12345aef/0", rd, err); end
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, lat, err, rd, nwr, a, r);
    last_rdata = ref_load(2'd2, 1'b0, 32'h0);
    checks++; if (rd !== last_rdata) begin errors++; $display("FAIL err_mem0: got %h expected %h", rd, last_rdata); end
  endtask

  task automatic test_back_to_back();
    int lat, nwr, a1, r1, a2, r2; logic err; logic [31:0] rd, wd;
    wd = $urandom;
    do_req(1'b1, 2'd2, 1'b0, 32'h20, wd, lat, err, rd, nwr, a1, r1);
    ref_store(2'd2, 32'h20, wd);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, lat, err, rd, nwr, a2, r2);
    checks++; if (a2 - r1 !== 2) begin errors++; $display("FAIL b2b_gap1: got %0d cycles expected 2", a2 - r1); end
    checks++; if (rd !== wd) begin errors++; $display("FAIL b2b_data1: got %h expected %h", rd, wd); end
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, lat, err, rd, nwr, a1, r1);
    last_rdata = 32'h00001234;
    checks++; if (a1 - r2 !== 2 || rd !== 32'h00001234) begin errors++; $display("FAIL b2b_2: gap %0d rdata %h expected 2/00001234", a1 - r2, rd); end
  endtask

  task automatic test_reset_mid();
    int w0, n, lat, nwr, a, r; logic err; logic [31:0] rd;
    n = 0;
    @(negedge Clk);
    while (!req_ready && n < 20) begin @(negedge Clk); n++; end
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_sign = 1'b0;
    req_addr = 32'h11; req_wdata = 32'hA5;
    @(posedge Clk); #1; req_valid = 1'b0;
    @(posedge Clk); #1;
    w0 = wr_count;
    Rst_n = 1'b0;
    #1;
    checks++; if (dm_DMWr !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL midrst_capt: dmwr %b resp_valid %b expected 0/0", dm_DMWr, resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h expected 0", resp_rdata); end
    last_rdata = 32'h0;
    @(negedge Clk); Rst_n = 1'b1;
    @(posedge Clk); #1;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || wr_count !== w0) begin errors++; $display("FAIL midrst_release: ready %b resp_valid %b writes %0d expected 1/0/0", req_ready, resp_valid, wr_count - w0); end
    // reset landing inside WRITE must drop DMWr immediately and prevent the write
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge Clk); #1; req_valid = 1'b0;
    checks++; if (dm_DMWr !== 1'b1) begin errors++; $display("FAIL midrst_write_active: got %b expected 1", dm_DMWr); end
    Rst_n = 1'b0;
    #1;
    checks++; if (dm_DMWr !== 1'b0) begin errors++; $display("FAIL midrst_dmwr_async: got %b expected 0", dm_DMWr); end
    @(negedge Clk); Rst_n = 1'b1;
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, err, rd, nwr, a, r);
    last_rdata = 32'h12345AEF;
    checks++; if (rd !== 32'h12345AEF || wr_count !== w0) begin errors++; $display("FAIL midrst_mem: got %h writes %0d expected 12345aef/0", rd, wr_count - w0); end
  endtask

  task automatic test_random();
    int lat, nwr, a, r, e_lat, e_wr; logic err, e_err, we, sign; logic [1:0] size;
    logic [31:0] addr, wd, rd;
    for (int n = 0; n < 120; n++) begin
      size = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = $urandom_range(0, DM_WORDS * 4 + 23);
      if ($urandom_range(0, 3) != 0 && size != 2'd3) addr = addr & ~((32'd1 << size) - 32'd1);
      we = 1'($urandom); sign = 1'($urandom); wd = $urandom;
      e_err = exp_err(size, addr);
      e_lat = e_err ? 1 : (we ? ((size == 2'd2) ? 2 : 4) : 3);
      e_wr = (!e_err && we) ? 1 : 0;
      do_req(we, size, sign, addr, wd, lat, err, rd, nwr, a, r);
      if (!e_err) begin
        if (we) ref_store(size, addr, wd);
        else last_rdata = ref_load(size, sign, addr);
      end
      checks++; if (lat !== e_lat) begin errors++; $display("FAIL rnd_lat #%0d: got %0d expected %0d", n, lat, e_lat); end
      checks++; if (err !== e_err) begin errors++; $display("FAIL rnd_err #%0d: got %b expected %b", n, err, e_err); end
      checks++; if (nwr !== e_wr) begin errors++; $display("FAIL rnd_writes #%0d: got %0d expected %0d", n, nwr, e_wr); end
      checks++; if (rd !== last_rdata) begin errors++; $display("FAIL rnd_rdata #%0d: got %h expected %h", n, rd, last_rdata); end
    end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_subword();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
